// File: rtl/mdu_core.sv
// mdu_core: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to add the madd/maddu accumulate ops (md_op 6/7).
module mdu_core #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;
    logic [5:0]              cnt, cnt_n;
    logic [2:0]              op_q, op_n;
    logic [WIDTH-1:0]        a_q, b_q, a_n, b_n, hi_n, lo_n, bd, quo, rem;
    logic signed [WIDTH-1:0] sq, sr;
    logic [W2-1:0]           prod, mres, res;
    logic                    sgn, is_div, ovf, legal, launch, wr;

    assign sgn    = ~op_q[0];
    assign is_div = op_q[1] & ~op_q[2];
    assign prod   = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q} * {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
    // Divisor is steered to 1 for zero and MIN/-1 so the divider never sees an undefined case.
    assign ovf    = sgn && a_q == {1'b1, {(WIDTH-1){1'b0}}} && &b_q;
    assign bd     = (b_q == '0 || ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
    assign sq     = $signed(a_q) / $signed(bd);
    assign sr     = $signed(a_q) % $signed(bd);
    assign quo    = ovf ? a_q : (sgn ? sq : a_q / bd);
    assign rem    = ovf ? '0 : (sgn ? sr : a_q % bd);
`ifdef MDU_MADD_EN
    assign mres   = op_q[2] ? {hi, lo} + prod : prod;
    assign legal  = ~md_op[2] | md_op[1];
`else
    assign mres   = prod;
    assign legal  = ~md_op[2];
`endif
    assign res    = is_div ? {rem, quo} : mres;
    assign wr     = ~(is_div && b_q == '0);
    assign launch = start && cnt == '0 && legal;

    always_comb begin
        cnt_n = cnt;
        op_n  = op_q;
        a_n   = a_q;
        b_n   = b_q;
        hi_n  = hi;
        lo_n  = lo;
        if (cnt == '0) begin
            if (launch) begin
                cnt_n = (md_op[1] & ~md_op[2]) ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
                op_n  = md_op;
                a_n   = a;
                b_n   = b;
            end else if (!start && md_op == 3'd4) begin
                hi_n = a;
            end else if (!start && md_op == 3'd5) begin
                lo_n = a;
            end
        end else begin
            cnt_n = cnt - 6'd1;
            if (cnt == 6'd1 && wr) {hi_n, lo_n} = res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            busy <= 1'b0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            cnt  <= cnt_n;
            busy <= cnt_n != '0;
            op_q <= op_n;
            a_q  <= a_n;
            b_q  <= b_n;
            hi   <= hi_n;
            lo   <= lo_n;
        end
    end
endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: randomized and directed checks of mdu_core against an arithmetic HI/LO model.
module tb_mdu_core;
    logic        clk, reset, start, busy;
    logic [2:0]  md_op;
    logic [31:0] a, b, hi, lo;
    logic [31:0] m_hi, m_lo;
    int          checks, passed;

    mdu_core dut (.clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
                  .busy(busy), .hi(hi), .lo(lo));

    always #5 clk = ~clk;

    function automatic int cycles_of(input logic [2:0] op);
`ifdef MDU_MADD_EN
        if (op == 6 || op == 7) return 5;
`else
        if (op == 6 || op == 7) return 0;
`endif
        return (op == 2 || op == 3) ? 10 : 5;
    endfunction

    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint signed   p;
        longint unsigned ux, uy;
        int              sx, sy;
        ux = x;
        uy = y;
        sx = x;
        sy = y;
        p  = longint'($signed(x)) * longint'($signed(y));
        case (op)
            0: {m_hi, m_lo} = p;
            1: {m_hi, m_lo} = ux * uy;
            2: if (y != 0) begin
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    m_lo = x;
                    m_hi = 0;
                end else begin
                    m_lo = sx / sy;
                    m_hi = sx % sy;
                end
            end
            3: if (y != 0) begin
                m_lo = x / y;
                m_hi = x % y;
            end
`ifdef MDU_MADD_EN
            6: {m_hi, m_lo} = {m_hi, m_lo} + p;
            7: {m_hi, m_lo} = {m_hi, m_lo} + ux * uy;
`endif
            default: ;
        endcase
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        start = 1;
        md_op = op;
        a = x;
        b = y;
        model(op, x, y);
        @(negedge clk);
        start = 0;
        md_op = 0;
    endtask

    task automatic finish(input string nm, input int n);
        int c = 0;
        while (busy && c < 200) begin
            c++;
            @(negedge clk);
        end
        checks++; if (c !== n) $display("FAIL %s busy_cycles got %0d want %0d", nm, c, n); else passed++;
        checks++; if (hi !== m_hi) $display("FAIL %s hi got %h want %h", nm, hi, m_hi); else passed++;
        checks++; if (lo !== m_lo) $display("FAIL %s lo got %h want %h", nm, lo, m_lo); else passed++;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] x);
        start = 0;
        md_op = op;
        a = x;
        if (op == 4) m_hi = x; else m_lo = x;
        @(negedge clk);
        md_op = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (2) @(negedge clk);
        m_hi = 0;
        m_lo = 0;
        checks++; if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else passed++;
        checks++; if (hi !== 32'h0) $display("FAIL reset hi got %h want 0", hi); else passed++;
        checks++; if (lo !== 32'h0) $display("FAIL reset lo got %h want 0", lo); else passed++;
        reset = 0;
    endtask

    task automatic test_directed;
        launch(0, 32'hFFFF_FFFF, 32'd2); finish("mult", 5);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL mult_const got %h%h want ffffffff_fffffffe", hi, lo); else passed++;
        launch(1, 32'hFFFF_FFFF, 32'd2); finish("multu", 5);
        checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) $display("FAIL multu_const got %h%h want 00000001_fffffffe", hi, lo); else passed++;
        launch(2, 32'hFFFF_FFF9, 32'd2); finish("div_neg", 10);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg_const got %h%h want ffffffff_fffffffd", hi, lo); else passed++;
        launch(2, 32'h8000_0000, 32'hFFFF_FFFF); finish("div_ovf", 10);
        checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) $display("FAIL div_ovf_const got %h%h want 00000000_80000000", hi, lo); else passed++;
    endtask

    task automatic test_div_zero;
        mt(4, 32'h12);
        mt(5, 32'h34);
        launch(3, 32'h1234, 32'd0); finish("divu_zero", 10);
        checks++; if ({hi, lo} !== {32'h12, 32'h34}) $display("FAIL divu_zero_const got %h%h want 00000012_00000034", hi, lo); else passed++;
    endtask

    task automatic test_reset_mid;
        mt(4, 32'h77);
        launch(0, 32'd9, 32'd9);
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        m_hi = 0;
        m_lo = 0;
        checks++; if (busy !== 1'b0) $display("FAIL rst_mid busy got %b want 0", busy); else passed++;
        checks++; if ({hi, lo} !== 64'h0) $display("FAIL rst_mid hilo got %h%h want 0", hi, lo); else passed++;
        repeat (8) @(negedge clk);
        checks++; if ({busy, hi, lo} !== 65'h0) $display("FAIL rst_mid_late got busy=%b %h%h want 0", busy, hi, lo); else passed++;
    endtask

    task automatic test_busy_ignore;
        launch(0, 32'd3, 32'd5);
        md_op = 4;
        a = 32'h55;
        @(negedge clk);
        start = 1;
        md_op = 2;
        a = 32'd100;
        b = 32'd7;
        @(negedge clk);
        start = 0;
        md_op = 0;
        finish("busy_ignore", 3);
        mt(5, 32'h66);
        checks++; if (lo !== 32'h66) $display("FAIL mtlo got %h want 00000066", lo); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mtlo busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_madd;
        mt(4, 32'h0);
        mt(5, 32'h5);
        launch(6, 32'd3, 32'd4); finish("madd", cycles_of(3'd6));
        repeat (3) @(negedge clk);
`ifdef MDU_MADD_EN
        checks++; if (lo !== 32'h11) $display("FAIL madd_const lo got %h want 00000011", lo); else passed++;
`else
        checks++; if (lo !== 32'h5) $display("FAIL madd_off lo got %h want 00000005", lo); else passed++;
`endif
        checks++; if (busy !== 1'b0 || hi !== 32'h0) $display("FAIL madd_tail busy=%b hi=%h want 0 0", busy, hi); else passed++;
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] x, y;
        for (int i = 0; i < 60; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = $urandom_range(1, 9);
                default: ;
            endcase
            op = 3'($urandom_range(0, 7));
            if (op == 4 || op == 5) begin
                mt(op, x);
                checks++; if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL rand_mt%0d got %h%h want %h%h", i, hi, lo, m_hi, m_lo); else passed++;
            end else begin
                launch(op, x, y);
                finish($sformatf("rand_op%0d_%0d", op, i), cycles_of(op));
            end
        end
    endtask

    initial begin
        clk = 0;
        reset = 1;
        start = 0;
        md_op = 0;
        a = 0;
        b = 0;
        checks = 0;
        passed = 0;
        m_hi = 0;
        m_lo = 0;
        @(negedge clk);
        test_reset;
        test_directed;
        test_div_zero;
        test_reset_mid;
        test_busy_ignore;
        test_madd;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mdu_core.md
MDU_CORE -- requirements
Module: mdu_core

Interface
REQ-001 SHALL take parameter WIDTH, default 32: operand and HI/LO width.
REQ-002 SHALL take parameter MULT_CYCLES, default 5: busy cycles for mult/multu/madd/maddu, legal range 1..63.
REQ-003 SHALL take parameter DIV_CYCLES, default 10: busy cycles for div/divu, legal range 1..63.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: launch a multi-cycle operation.
REQ-007 SHALL have port md_op, input, 3 bits: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: operand rs and operand rt.
REQ-009 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-010 SHALL have ports hi and lo, output, WIDTH bits each: architectural HI and LO registers.

Function
REQ-011 SHALL be IDLE when the counter is 0 and RUN when the counter is nonzero; busy SHALL equal (counter != 0), registered.
REQ-012 SHALL, in IDLE with start=1 and md_op in {0,1,2,3} (or {6,7} when enabled), latch a and b and the op at that edge, load the counter with MULT_CYCLES or DIV_CYCLES, and raise busy from the next cycle.
REQ-013 SHALL keep busy high for exactly N cycles after the start edge; on the edge ending the Nth busy cycle, SHALL write the result to HI/LO and clear the counter, so the new HI/LO and busy=0 are visible together.
REQ-014 SHALL ignore start while busy=1; latched operands SHALL not change.
REQ-015 SHALL ignore start=1 with md_op 4 or 5, and SHALL ignore md_op 6 or 7 when MDU_MADD_EN is undefined.
REQ-016 SHALL, in IDLE with start=0 and md_op=4 (or 5), write a to HI (or LO) at that edge; this write SHALL be ignored while busy=1.
REQ-017 SHALL, for mult, set HI:LO to the signed 2*WIDTH-bit product; for multu, to the unsigned product.
REQ-018 SHALL, for div, set LO to the signed quotient truncated toward zero and HI to a remainder carrying the dividend's sign; for divu, to the unsigned quotient and remainder.
REQ-019 SHALL, for signed MIN/-1, set LO=MIN and HI=0.
REQ-020 SHALL, for divide by zero, still run DIV_CYCLES busy cycles and leave HI/LO unchanged.
REQ-021 SHALL compute madd/maddu results from the HI:LO value at the completion edge, wrapping modulo 2^(2*WIDTH).

Reset
REQ-022 SHALL, with reset=1 at an edge, set counter=0, busy=0, hi=0, lo=0 and clear the latched operands and op, regardless of state.
REQ-023 SHALL, when reset is applied mid-operation, abandon the operation with no HI/LO write; reset SHALL take priority over start, mthi/mtlo and completion in the same cycle.

Configuration
REQ-024 SHALL, with macro MDU_MADD_EN defined, support md_op 6 (madd: HI:LO += signed a*b) and 7 (maddu: HI:LO += unsigned a*b), each taking MULT_CYCLES.
REQ-025 SHALL, without MDU_MADD_EN, contain no accumulate logic, and md_op 6/7 SHALL be no-ops (busy stays 0, HI/LO unchanged).

Verification
REQ-026 SHALL cover: mult a=0xFFFFFFFF b=2 -> busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-027 SHALL cover: div a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; div a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000 HI=0.
REQ-028 SHALL cover: HI=0x12 LO=0x34, then divu b=0 -> busy 10 cycles, then HI=0x12 LO=0x34 unchanged.
REQ-029 SHALL cover: start mult, reset=1 in the 3rd busy cycle -> next cycle busy=0, HI=0, LO=0; no later write.
REQ-030 SHALL cover: mthi a=0x55 while busy -> HI unaffected by the mthi; mtlo a=0x66 while idle -> LO=0x66 after one edge; start during busy ignored, first result intact.
REQ-031 SHALL cover, with MDU_MADD_EN: HI=0 LO=5, then madd a=3 b=4 -> after 5 busy cycles LO=0x11 HI=0; without the macro, the same stimulus leaves LO=5 and busy=0.
